id_ex_pipeline_reg: RTL
=======================

// Module: id_ex_pipeline_reg
// PURPOSE
//  ID/EX pipeline register sitting directly downstream of the opcode decoder.
//  Captures the decoder's 9-bit control bundle plus ID-stage operands, and applies stall (hold) and flush (bubble).
//  Scrubs the decoder's don't-care control fields to known values.
//  Emits the load-use hazard request back to the IF/ID stage, and counts inserted bubbles for debug.
// PARAMETERS
//  XLEN        32  datapath width (operands, imm, pc)
//  RADDR_W      5  register-file address width
//  CNT_W       16  bubble-counter width
// PORTS
//  clk            in   1        rising-edge clock
//  reset          in   1        asynchronous, active-high; clears all state
//  stall          in   1        hold ID/EX contents this cycle
//  flush          in   1        load a bubble (branch/jump redirect)
//  id_valid       in   1        ID stage holds a real instruction
//  id_ctrl        in   9        {ALUsrc,MemtoReg,Regwrite,MemRead,MemWrite,Branch,Jump,ALUop[1:0]}
//  id_pc          in   XLEN     instruction PC
//  id_rs1_data    in   XLEN     register operand 1
//  id_rs2_data    in   XLEN     register operand 2
//  id_imm         in   XLEN     sign-extended immediate
//  id_rs1         in   RADDR_W  source register 1 address
//  id_rs2         in   RADDR_W  source register 2 address
//  id_rd          in   RADDR_W  destination register address
//  id_funct3      in   3        funct3 field
//  id_funct7b5    in   1        instruction bit 30
//  ex_valid       out  1        EX holds a real instruction
//  ex_ctrl        out  9        scrubbed control bundle; same bit order as id_ctrl
//  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm   out  XLEN   registered copies
//  ex_rs1, ex_rs2, ex_rd                     out  RADDR_W  registered copies
//  ex_funct3      out  3        registered copy
//  ex_funct7b5    out  1        registered copy
//  load_use_stall out  1        request to stall IF/ID and bubble ID/EX
//  bubble_count   out  CNT_W    saturating count of bubbles inserted
// BEHAVIOUR
//  - Reset: every output and register is 0. Reset is asynchronous and has priority mid-operation; in-flight state is discarded.
//  - Priority per rising edge: flush > (stall | load_use_stall) > load.
//  - Load: all ex_* take id_* next cycle (latency 1). ex_valid <= id_valid.
//  - Bubble (flush, or load_use_stall & ~stall): ex_valid <= 0 and ex_ctrl <= 0.
//    Data fields are don't-care but are also cleared, so waveforms stay X-free.
//  - Stall without flush: all state holds.
//  - Scrub on load:
//    - ex_ctrl <= 0 when id_valid=0.
//    - MemtoReg forced 0 when Regwrite=0.
//    - MemRead and MemWrite forced 0 when both are set.
//    - Each remaining ctrl bit is 0 unless the input bit is 1 (an X or Z input bit registers as 0).
//  - load_use_stall is combinational from registered state, with no reset-edge glitch:
//    ex_valid & ex_ctrl[MemRead] & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
//    It is masked when flush=1.
//  - bubble_count increments by 1 on each bubble edge and saturates at all-ones. It does not wrap.
//  - Simultaneous flush and load_use_stall: a single bubble, counted once.
// STRUCTURE
//  - Shared package pipe_pkg:
//    - CTRL_W=9 and the bit-index localparams (CTRL_ALUSRC=8 … CTRL_ALUOP LSB=0).
//    - ALUop encodings.
//    - The opcode constants already used by the decoder.
//  - One sub-module, hazard_load_use: the combinational load_use_stall compare. It is reused later by the forwarding unit.
//  - Register bank is flat in this module; no FSM beyond the valid/bubble logic and the counter.
// TESTING
//  1. Reset mid-stream: assert reset with ex_valid=1 -> all outputs 0 immediately; bubble_count=0.
//  2. Load R-type: id_ctrl=9'b001000010, id_valid=1, rd=5 -> next cycle ex_ctrl=9'b001000010, ex_rd=5, ex_valid=1.
//  3. Load-use: EX holds lw x5; ID holds add rs1=x5 -> load_use_stall=1, next ex_valid=0, bubble_count=1. With rd=x0 -> no stall.
//  4. Scrub: S-type id_ctrl=9'b1x0010000 -> ex_ctrl=9'b100010000. id_valid=0 with any ctrl -> ex_ctrl=0.
//  5. Flush vs stall: flush=1 and stall=1 on the same edge -> bubble loaded, counted once. Stall alone for 3 cycles -> outputs constant.
//  6. Saturation: CNT_W=4 override, 20 consecutive flushes -> bubble_count stops at 4'hF.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: control-bundle layout, ALUop encodings and opcodes shared by decoder and pipeline
package pipe_pkg;
  localparam int CTRL_W        = 9;
  localparam int CTRL_ALUSRC   = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_REGWRITE = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_JUMP     = 2;
  localparam int CTRL_ALUOP_MSB = 1;
  localparam int CTRL_ALUOP_LSB = 0;
  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// id_ex_pipeline_reg_if: ID-side inputs and EX-side outputs of the ID/EX register
interface id_ex_pipeline_reg_if import pipe_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) ();
  logic               stall, flush, id_valid;
  logic [CTRL_W-1:0]  id_ctrl;
  logic [XLEN-1:0]    id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RADDR_W-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0]         id_funct3;
  logic               id_funct7b5;
  logic               ex_valid;
  logic [CTRL_W-1:0]  ex_ctrl;
  logic [XLEN-1:0]    ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [RADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0]         ex_funct3;
  logic               ex_funct7b5;
  logic               load_use_stall;
  logic [CNT_W-1:0]   bubble_count;
  modport master (
    output stall, flush, id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
    input  ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, load_use_stall, bubble_count
  );
  modport slave (
    input  stall, flush, id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
    output ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, load_use_stall, bubble_count
  );
endinterface

// File: rtl/hazard_load_use.sv
// hazard_load_use: detects an ID instruction reading the destination of a load sitting in EX
module hazard_load_use #(
  parameter int RADDR_W = 5
) (
  input  logic               ex_valid_i,
  input  logic               ex_memread_i,
  input  logic [RADDR_W-1:0] ex_rd_i,
  input  logic               id_valid_i,
  input  logic [RADDR_W-1:0] id_rs1_i,
  input  logic [RADDR_W-1:0] id_rs2_i,
  input  logic               flush_i,
  output logic               stall_o
);
  assign stall_o = ex_valid_i & ex_memread_i & (ex_rd_i != '0) & id_valid_i &
                   ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i)) & ~flush_i;
endmodule

// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID/EX register with stall, flush, control scrubbing and bubble counter
module id_ex_pipeline_reg import pipe_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic reset,
  id_ex_pipeline_reg_if.slave bus
);
  localparam int DW = 4*XLEN + 3*RADDR_W + 4;
  logic              valid_q, valid_d, lus, bubble, hold;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d, ctrl_s;
  logic [DW-1:0]     data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  hazard_load_use #(.RADDR_W(RADDR_W)) u_hazard (
    .ex_valid_i   (valid_q),
    .ex_memread_i (ctrl_q[CTRL_MEMREAD]),
    .ex_rd_i      (bus.ex_rd),
    .id_valid_i   (bus.id_valid),
    .id_rs1_i     (bus.id_rs1),
    .id_rs2_i     (bus.id_rs2),
    .flush_i      (bus.flush),
    .stall_o      (lus)
  );
  // if-form keeps unknown input bits registering as 0 rather than propagating
  always_comb begin
    ctrl_s = '0;
    for (int i = 0; i < CTRL_W; i++)
      if (bus.id_ctrl[i]) ctrl_s[i] = 1'b1;
    if (!bus.id_valid) ctrl_s = '0;
    if (!ctrl_s[CTRL_REGWRITE]) ctrl_s[CTRL_MEMTOREG] = 1'b0;
    if (ctrl_s[CTRL_MEMREAD] && ctrl_s[CTRL_MEMWRITE]) begin
      ctrl_s[CTRL_MEMREAD]  = 1'b0;
      ctrl_s[CTRL_MEMWRITE] = 1'b0;
    end
  end
  assign bubble  = bus.flush | (lus & ~bus.stall);
  assign hold    = bus.stall & ~bus.flush;
  assign valid_d = bubble ? 1'b0 : hold ? valid_q : bus.id_valid;
  assign ctrl_d  = bubble ? '0 : hold ? ctrl_q : ctrl_s;
  assign data_d  = bubble ? '0 : hold ? data_q :
                   {bus.id_pc, bus.id_rs1_data, bus.id_rs2_data, bus.id_imm,
                    bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_funct3, bus.id_funct7b5};
  assign cnt_d   = (bubble && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.ex_valid       = valid_q;
  assign bus.ex_ctrl        = ctrl_q;
  assign bus.load_use_stall = lus;
  assign bus.bubble_count   = cnt_q;
  assign {bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm,
          bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_funct3, bus.ex_funct7b5} = data_q;
endmodule
